vga_fb_pixel_stream_striped: RTL and testbench

//  Walks a VGA raster (visible + blanking), reads each visible pixel from a framebuffer striped across NUM_S
//  AXI-Lite read ports, and emits one pixel per valid pulse in raster order. Each pixel carries its color,

---
 rtl/vga_fb_pkg.sv | 31 +++
 rtl/vga_raster_counter.sv | 57 +++++
 rtl/vga_fb_pixel_stream_striped.sv | 166 ++++++++++++++++
 tb/tb_vga_fb_pixel_stream_striped.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared definitions for the striped framebuffer pixel streamer: fetch FSM states,
// sync-window and stripe mapping helpers.
package vga_fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    EMIT
  } fetch_state_t;

  function automatic int unsigned sync_start(input int unsigned visible,
                                             input int unsigned front_porch);
    return visible + front_porch;
  endfunction

  function automatic int unsigned sync_end(input int unsigned visible,
                                           input int unsigned front_porch,
                                           input int unsigned sync_pulse);
    return visible + front_porch + sync_pulse;
  endfunction

  function automatic int unsigned stripe_idx(input int unsigned a, input int unsigned n);
    return a % n;
  endfunction

  function automatic int unsigned stripe_addr(input int unsigned a, input int unsigned n);
    return a / n;
  endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// Raster position counter: steps x/y on advance and decodes syncs, visibility and
// the linear framebuffer address of the current position.
module vga_raster_counter
  import vga_fb_pkg::*;
#(
  parameter int unsigned H_VISIBLE     = 640,
  parameter int unsigned H_FRONT_PORCH = 16,
  parameter int unsigned H_SYNC_PULSE  = 96,
  parameter int unsigned H_WHOLE_LINE  = 800,
  parameter int unsigned V_VISIBLE     = 480,
  parameter int unsigned V_FRONT_PORCH = 10,
  parameter int unsigned V_SYNC_PULSE  = 2,
  parameter int unsigned V_WHOLE_FRAME = 525,
  parameter int unsigned ADDR_WIDTH    = 20,
  localparam int unsigned XW = $clog2(H_WHOLE_LINE),
  localparam int unsigned YW = $clog2(V_WHOLE_FRAME)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  output logic [XW-1:0]         x,
  output logic [YW-1:0]         y,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  visible,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int unsigned H_SYNC_START = sync_start(H_VISIBLE, H_FRONT_PORCH);
  localparam int unsigned H_SYNC_END   = sync_end(H_VISIBLE, H_FRONT_PORCH, H_SYNC_PULSE);
  localparam int unsigned V_SYNC_START = sync_start(V_VISIBLE, V_FRONT_PORCH);
  localparam int unsigned V_SYNC_END   = sync_end(V_VISIBLE, V_FRONT_PORCH, V_SYNC_PULSE);

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (32'(x) == H_WHOLE_LINE - 1) begin
        x <= '0;
        if (32'(y) == V_WHOLE_FRAME - 1) y <= '0;
        else                             y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Compare in 32 bits so a sync window ending exactly at the line length still decodes.
  always_comb begin
    hsync   = !((32'(x) >= H_SYNC_START) && (32'(x) < H_SYNC_END));
    vsync   = !((32'(y) >= V_SYNC_START) && (32'(y) < V_SYNC_END));
    visible = (32'(x) < H_VISIBLE) && (32'(y) < V_VISIBLE);
    addr    = ADDR_WIDTH'(32'(y) * H_VISIBLE + 32'(x));
  end

endmodule

// File: rtl/vga_fb_pixel_stream_striped.sv
// VGA raster pixel streamer reading a framebuffer striped over NUM_S AXI-Lite read ports.
// Define VGA_FB_STRIPED_PREFETCH_EN for two group buffers (next group fetched while current emits).
module vga_fb_pixel_stream_striped
  import vga_fb_pkg::*;
#(
  parameter int unsigned NUM_S          = 2,
  parameter int unsigned PIXEL_BITS     = 12,
  parameter int unsigned H_VISIBLE      = 640,
  parameter int unsigned H_FRONT_PORCH  = 16,
  parameter int unsigned H_SYNC_PULSE   = 96,
  parameter int unsigned H_BACK_PORCH   = 48,
  parameter int unsigned H_WHOLE_LINE   = 800,
  parameter int unsigned V_VISIBLE      = 480,
  parameter int unsigned V_FRONT_PORCH  = 10,
  parameter int unsigned V_SYNC_PULSE   = 2,
  parameter int unsigned V_BACK_PORCH   = 33,
  parameter int unsigned V_WHOLE_FRAME  = 525,
  parameter int unsigned AXI_ADDR_WIDTH = 20,
  parameter int unsigned AXI_DATA_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  output logic                                  valid,
  output logic                                  vsync,
  output logic                                  hsync,
  output logic                                  visible,
  output logic [PIXEL_BITS-1:0]                 color,
  output logic [AXI_ADDR_WIDTH-1:0]             addr,
  output logic [NUM_S-1:0][AXI_ADDR_WIDTH-1:0]  fb_axi_araddr,
  output logic [NUM_S-1:0]                      fb_axi_arvalid,
  input  logic [NUM_S-1:0]                      fb_axi_arready,
  input  logic [NUM_S-1:0][AXI_DATA_WIDTH-1:0]  fb_axi_rdata,
  input  logic [NUM_S-1:0][1:0]                 fb_axi_rresp,
  input  logic [NUM_S-1:0]                      fb_axi_rvalid,
  output logic [NUM_S-1:0]                      fb_axi_rready
);

`ifdef VGA_FB_STRIPED_PREFETCH_EN
  localparam int unsigned NBUF = 2;
`else
  localparam int unsigned NBUF = 1;
`endif
  localparam int unsigned SW        = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int unsigned FRAME_PIX = H_VISIBLE * V_VISIBLE;
  localparam int unsigned XW        = $clog2(H_WHOLE_LINE);
  localparam int unsigned YW        = $clog2(V_WHOLE_FRAME);

  fetch_state_t state, state_next;

  logic [NUM_S-1:0]      ar_done, r_got;
  logic [31:0]           fetch_addr;
  logic [NBUF-1:0]       slot_full;
  logic                  fill_slot, emit_slot;
  logic [PIXEL_BITS-1:0] gbuf [NBUF][NUM_S];

  logic [XW-1:0]             rx;
  logic [YW-1:0]             ry;
  logic                      r_hsync, r_vsync, r_visible;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic                      emit, last_lane;
  logic [SW-1:0]             lane;
  logic                      unused_bits;

  assign unused_bits = ^{fb_axi_rresp, fb_axi_rdata, ry, 32'(H_BACK_PORCH), 32'(V_BACK_PORCH)};

  vga_raster_counter #(
    .H_VISIBLE     (H_VISIBLE),
    .H_FRONT_PORCH (H_FRONT_PORCH),
    .H_SYNC_PULSE  (H_SYNC_PULSE),
    .H_WHOLE_LINE  (H_WHOLE_LINE),
    .V_VISIBLE     (V_VISIBLE),
    .V_FRONT_PORCH (V_FRONT_PORCH),
    .V_SYNC_PULSE  (V_SYNC_PULSE),
    .V_WHOLE_FRAME (V_WHOLE_FRAME),
    .ADDR_WIDTH    (AXI_ADDR_WIDTH)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .advance (emit),
    .x       (rx),
    .y       (ry),
    .hsync   (r_hsync),
    .vsync   (r_vsync),
    .visible (r_visible),
    .addr    (r_addr)
  );

  // Fetch runs only while the raster is in the visible area, so blanking never causes AXI traffic.
  // EMIT is the single cycle in which a completed group is handed to the emitter's buffer.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (enable && r_visible && !slot_full[fill_slot]) state_next = ISSUE;
      ISSUE:  if (&(ar_done | (fb_axi_arvalid & fb_axi_arready))) state_next = WAIT_R;
      WAIT_R: if (&(r_got | (fb_axi_rready & fb_axi_rvalid))) state_next = EMIT;
      EMIT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fb_axi_arvalid = (state == ISSUE) ? ~ar_done : '0;
    fb_axi_rready  = (state == ISSUE || state == WAIT_R) ? ~r_got : '0;
    emit           = enable && (!r_visible || slot_full[emit_slot]);
    lane           = SW'(stripe_idx(32'(rx), NUM_S));
    last_lane      = (32'(lane) == NUM_S - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ar_done       <= '0;
      r_got         <= '0;
      fetch_addr    <= '0;
      slot_full     <= '0;
      fill_slot     <= 1'b0;
      emit_slot     <= 1'b0;
      fb_axi_araddr <= '0;
      valid         <= 1'b0;
      hsync         <= 1'b1;
      vsync         <= 1'b1;
      visible       <= 1'b0;
      color         <= '0;
      addr          <= '0;
    end else begin
      state <= state_next;

      if (state == IDLE && state_next == ISSUE) begin
        ar_done <= '0;
        r_got   <= '0;
        for (int unsigned s = 0; s < NUM_S; s++)
          fb_axi_araddr[s] <= AXI_ADDR_WIDTH'(stripe_addr(fetch_addr, NUM_S));
      end else begin
        ar_done <= ar_done | (fb_axi_arvalid & fb_axi_arready);
        r_got   <= r_got | (fb_axi_rready & fb_axi_rvalid);
      end

      valid <= emit;
      if (emit) begin
        hsync   <= r_hsync;
        vsync   <= r_vsync;
        visible <= r_visible;
        addr    <= r_addr;
        color   <= r_visible ? gbuf[emit_slot][lane] : '0;
        if (r_visible && last_lane) begin
          slot_full[emit_slot] <= 1'b0;
          if (NBUF > 1) emit_slot <= ~emit_slot;
        end
      end

      if (state == EMIT) begin
        slot_full[fill_slot] <= 1'b1;
        if (NBUF > 1) fill_slot <= ~fill_slot;
        fetch_addr <= (fetch_addr + NUM_S >= FRAME_PIX) ? '0 : fetch_addr + NUM_S;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < NUM_S; s++)
      if (fb_axi_rready[s] && fb_axi_rvalid[s])
        gbuf[fill_slot][s] <= fb_axi_rdata[s][PIXEL_BITS-1:0];
  end

endmodule

// File: tb/tb_vga_fb_pixel_stream_striped.sv
// Randomized bench for vga_fb_pixel_stream_striped: per-stripe SRAM responders with random
// ready/latency, and a raster-position reference model checking every emitted pixel.
module tb_vga_fb_pixel_stream_striped;

  localparam int NS = 2, PB = 12, AW = 10, DW = 16;
  localparam int HV = 16, HF = 2, HS = 3, HB = 2, HW = 23;
  localparam int VV = 8, VF = 2, VS = 3, VB = 3, VW = 16;
  localparam int FRAME_PIX = HW * VW;
  localparam int WORDS     = HV * VV / NS;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   enable = 1'b0;
  logic                   valid, vsync, hsync, visible;
  logic [PB-1:0]          color;
  logic [AW-1:0]          addr;
  logic [NS-1:0][AW-1:0]  araddr;
  logic [NS-1:0]          arvalid;
  logic [NS-1:0]          arready = '0;
  logic [NS-1:0][DW-1:0]  rdata = '0;
  logic [NS-1:0][1:0]     rresp = '0;
  logic [NS-1:0]          rvalid = '0;
  logic [NS-1:0]          rready;

  int n_checks = 0, n_pass = 0, n_valid = 0;
  int ex = 0, ey = 0;
  bit last_blank = 1'b0;
  bit pend [NS];
  int cnt [NS], paddr [NS], exp_word [NS];

  always #5 clk = ~clk;

  vga_fb_pixel_stream_striped #(
    .NUM_S(NS), .PIXEL_BITS(PB),
    .H_VISIBLE(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB), .H_WHOLE_LINE(HW),
    .V_VISIBLE(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB), .V_WHOLE_FRAME(VW),
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .valid(valid), .vsync(vsync), .hsync(hsync), .visible(visible),
    .color(color), .addr(addr),
    .fb_axi_araddr(araddr), .fb_axi_arvalid(arvalid), .fb_axi_arready(arready),
    .fb_axi_rdata(rdata), .fb_axi_rresp(rresp), .fb_axi_rvalid(rvalid), .fb_axi_rready(rready)
  );

  function automatic logic [DW-1:0] word_of(input int s, input int w);
    return DW'((w * 16'h0123) ^ (s * 16'h0a50) ^ 16'h5c3b);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // SRAM responders: each negedge drive this cycle's inputs, then account for the
  // handshakes the DUT will see at the coming posedge.
  always @(negedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (reset) begin
        pend[s] = 1'b0; cnt[s] = 0; exp_word[s] = 0;
        arready[s] = 1'b0; rvalid[s] = 1'b0; rdata[s] = '0;
      end else begin
        rvalid[s]  = pend[s] && (cnt[s] == 0);
        rdata[s]   = rvalid[s] ? word_of(s, paddr[s]) : DW'($urandom);
        rresp[s]   = 2'($urandom);
        arready[s] = !pend[s] && ($urandom_range(0, 3) != 0);
        if (rvalid[s] && rready[s]) pend[s] = 1'b0;
        else if (pend[s] && cnt[s] > 0) cnt[s]--;
        if (arvalid[s] && arready[s]) begin
          check_eq("araddr_order", 32'(araddr[s]), 32'(exp_word[s]));
          exp_word[s] = (exp_word[s] + 1) % WORDS;
          pend[s] = 1'b1; paddr[s] = int'(araddr[s]); cnt[s] = $urandom_range(0, 2);
        end
      end
    end
  end

  // Reference raster model: every valid must be the next raster position.
  always @(negedge clk) begin
    if (reset) begin
      ex = 0; ey = 0; last_blank = 1'b0;
    end else begin
      if (valid) begin
        int a;
        bit vis;
        logic [DW-1:0] w;
        a   = ey * HV + ex;
        vis = (ex < HV) && (ey < VV);
        w   = word_of(a % NS, a / NS);
        check_eq("addr", 32'(addr), 32'(a));
        check_eq("visible", 32'(visible), 32'(vis));
        check_eq("hsync", 32'(hsync), 32'(!(ex >= HV + HF && ex < HV + HF + HS)));
        check_eq("vsync", 32'(vsync), 32'(!(ey >= VV + VF && ey < VV + VF + VS)));
        check_eq("color", 32'(color), vis ? 32'(w[PB-1:0]) : 32'd0);
        n_valid++;
        last_blank = !vis;
        ex++;
        if (ex == HW) begin ex = 0; ey = (ey + 1) % VW; end
      end
      if (last_blank && !((ex < HV) && (ey < VV)))
        check_eq("blank_arvalid", 32'(arvalid), 32'd0);
    end
  end

  task automatic wait_pixels(input int target, input int budget);
    int c;
    c = 0;
    while (n_valid < target && c < budget) begin
      @(posedge clk); #2;
      c++;
    end
    check_eq("progress", 32'(n_valid >= target), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_hsync", 32'(hsync), 32'd1);
    check_eq("rst_vsync", 32'(vsync), 32'd1);
    check_eq("rst_visible", 32'(visible), 32'd0);
    check_eq("rst_color", 32'(color), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_arvalid", 32'(arvalid), 32'd0);
    check_eq("rst_rready", 32'(rready), 32'd0);
  endtask

  initial begin
    int target;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    reset  = 1'b0;
    enable = 1'b1;

    // stall for 10 cycles in the middle of line 3 of the second frame
    wait_pixels(FRAME_PIX + 3 * HW + 5, 20000);
    enable = 1'b0;
    repeat (10) begin
      @(posedge clk); #2;
      check_eq("stall_valid", 32'(valid), 32'd0);
    end
    enable = 1'b1;

    wait_pixels(3 * FRAME_PIX, 20000);
    wait_pixels(3 * FRAME_PIX + 150, 5000);

    reset = 1'b1;
    @(posedge clk); #2;
    check_reset_outputs();
    @(posedge clk); #2;
    reset = 1'b0;
    for (int c = 0; c < 100 && !valid; c++) begin
      @(posedge clk); #2;
    end
    check_eq("restart_valid", 32'(valid), 32'd1);
    check_eq("restart_addr", 32'(addr), 32'd0);
    check_eq("restart_visible", 32'(visible), 32'd1);

    target = n_valid + 100;
    wait_pixels(target, 5000);
    enable = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
